// File: rtl/vga_axil_master_fsm_if.sv
// ----------------------------------------------------------------------------
// vga_axil_master_fsm_if
//   AXI4-Lite bus bundle between the native-request master and a slave.
//
//   Parameters : ADDR_WIDTH - byte address width
//                DATA_WIDTH - data width (32 or 64)
//   Channels   : AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//                B (bresp/bvalid/bready), AR (araddr/arvalid/arready),
//                R (rdata/rresp/rvalid/rready)
//   Modports   : master - drives the address/data/ready-for-response side
//                slave  - drives the ready/response side
// ----------------------------------------------------------------------------
interface vga_axil_master_fsm_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, input  awready,
        output wdata, wstrb, wvalid, input  wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input  arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input  bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input  rready
    );
endinterface

// File: rtl/vga_axil_master_fsm.sv
// ----------------------------------------------------------------------------
// vga_axil_master_fsm
//   Converts single-beat native write/read requests into AXI4-Lite
//   transactions. The write and read paths are independent FSMs that run
//   concurrently; all outputs are registered.
//
//   Parameters : ADDR_WIDTH - byte address width
//                DATA_WIDTH - data width, 32 or 64 (must match the interface)
//   Ports      : clk, rst          - single clock, synchronous active-high reset
//                wr_req_i/addr/data - write request, taken while wr_ready_o=1
//                wr_ready_o         - write FSM idle
//                wr_done_o          - one-cycle pulse at write completion
//                wr_resp_o          - BRESP of the completed write
//                rd_req_i/rd_addr_i - read request, taken while rd_ready_o=1
//                rd_ready_o         - read FSM idle
//                rd_done_o          - one-cycle pulse at read completion
//                rd_data_o/rd_resp_o- RDATA/RRESP, held until the next read
//                axi                - AXI4-Lite master modport
// ----------------------------------------------------------------------------
module vga_axil_master_fsm #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  wr_req_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_ready_o,
    output logic                  wr_done_o,
    output logic [1:0]            wr_resp_o,

    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rd_ready_o,
    output logic                  rd_done_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [1:0]            rd_resp_o,

    vga_axil_master_fsm_if.master axi
);

    localparam int unsigned BYTE_LANES = DATA_WIDTH / 8;
    // Clears the byte-offset bits so every access is bus-word aligned.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTE_LANES - 1);

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } r_state_e;

    // ------------------------------------------------------------------
    // Write path registers
    // ------------------------------------------------------------------
    w_state_e              w_state_q;
    logic                  wr_ready_q;
    logic                  wr_done_q;
    logic [1:0]            wr_resp_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  bready_q;

    // A channel is still outstanding after this edge when its valid is up
    // and the slave has not accepted it. Either order of AW/W completion
    // (or both together) is covered by testing both of these.
    logic aw_pend_d;
    logic w_pend_d;

    assign aw_pend_d = awvalid_q & ~axi.awready;
    assign w_pend_d  = wvalid_q  & ~axi.wready;

    always_ff @(posedge clk) begin
        // NOTE: payload registers are reset along with control so that the
        // bus and result outputs read 0 straight after reset.
        if (rst) begin
            w_state_q  <= W_IDLE;
            wr_ready_q <= 1'b1;
            wr_done_q  <= 1'b0;
            wr_resp_q  <= 2'b00;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in
            // this block referring to pre-edge values, whatever the order.
            wr_done_q <= 1'b0;
            case (w_state_q)
                W_IDLE: begin
                    if (wr_req_i) begin
                        awaddr_q   <= wr_addr_i & ALIGN_MASK;
                        wdata_q    <= wr_data_i;
                        awvalid_q  <= 1'b1;
                        wvalid_q   <= 1'b1;
                        wr_ready_q <= 1'b0;
                        w_state_q  <= W_ADDR_DATA;
                    end
                end
                W_ADDR_DATA: begin
                    if (awvalid_q && axi.awready) awvalid_q <= 1'b0;
                    if (wvalid_q && axi.wready)   wvalid_q  <= 1'b0;
                    if (!aw_pend_d && !w_pend_d) begin
                        bready_q  <= 1'b1;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (axi.bvalid) begin
                        wr_resp_q  <= axi.bresp;
                        wr_done_q  <= 1'b1;
                        bready_q   <= 1'b0;
                        wr_ready_q <= 1'b1;
                        w_state_q  <= W_IDLE;
                    end
                end
                default: begin
                    awvalid_q  <= 1'b0;
                    wvalid_q   <= 1'b0;
                    bready_q   <= 1'b0;
                    wr_ready_q <= 1'b1;
                    w_state_q  <= W_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read path registers
    // ------------------------------------------------------------------
    r_state_e              r_state_q;
    logic                  rd_ready_q;
    logic                  rd_done_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [1:0]            rd_resp_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic                  arvalid_q;
    logic                  rready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= R_IDLE;
            rd_ready_q <= 1'b1;
            rd_done_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_resp_q  <= 2'b00;
            araddr_q   <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
        end else begin
            rd_done_q <= 1'b0;
            case (r_state_q)
                R_IDLE: begin
                    if (rd_req_i) begin
                        araddr_q   <= rd_addr_i & ALIGN_MASK;
                        arvalid_q  <= 1'b1;
                        rd_ready_q <= 1'b0;
                        r_state_q  <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (axi.rvalid) begin
                        rd_data_q  <= axi.rdata;
                        rd_resp_q  <= axi.rresp;
                        rd_done_q  <= 1'b1;
                        rready_q   <= 1'b0;
                        rd_ready_q <= 1'b1;
                        r_state_q  <= R_IDLE;
                    end
                end
                default: begin
                    arvalid_q  <= 1'b0;
                    rready_q   <= 1'b0;
                    rd_ready_q <= 1'b1;
                    r_state_q  <= R_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wr_ready_o  = wr_ready_q;
    assign wr_done_o   = wr_done_q;
    assign wr_resp_o   = wr_resp_q;
    assign rd_ready_o  = rd_ready_q;
    assign rd_done_o   = rd_done_q;
    assign rd_data_o   = rd_data_q;
    assign rd_resp_o   = rd_resp_q;

    assign axi.awaddr  = awaddr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = '1;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.araddr  = araddr_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

endmodule

// File: tb/tb_vga_axil_master_fsm.sv
// ----------------------------------------------------------------------------
// tb_vga_axil_master_fsm
//   Drives native requests and plays an AXI4-Lite slave with scheduled or
//   random handshake delays. A transaction-level model (busy flag plus one
//   "outstanding" flag per channel) predicts every registered output; a
//   single negedge process compares the DUT against it, and directed
//   sequences pin the model with hand-computed literals.
// ----------------------------------------------------------------------------
module tb_vga_axil_master_fsm;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [AW-1:0] ALIGN = 32'hFFFF_FFFC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready, wr_done;
    logic [1:0]    wr_resp;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_ready, rd_done;
    logic [DW-1:0] rd_data;
    logic [1:0]    rd_resp;

    vga_axil_master_fsm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    vga_axil_master_fsm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_req_i   (wr_req),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .wr_ready_o (wr_ready),
        .wr_done_o  (wr_done),
        .wr_resp_o  (wr_resp),
        .rd_req_i   (rd_req),
        .rd_addr_i  (rd_addr),
        .rd_ready_o (rd_ready),
        .rd_done_o  (rd_done),
        .rd_data_o  (rd_data),
        .rd_resp_o  (rd_resp),
        .axi        (axi)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit            m_wr_busy, m_aw_pend, m_w_pend, m_wr_done;
    logic [AW-1:0] m_awaddr = '0;
    logic [DW-1:0] m_wdata  = '0;
    logic [1:0]    m_wr_resp = '0;
    bit            m_rd_busy, m_ar_pend, m_rd_done;
    logic [AW-1:0] m_araddr  = '0;
    logic [DW-1:0] m_rd_data = '0;
    logic [1:0]    m_rd_resp = '0;

    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int aw_dly = 1, w_dly = 1, b_dly = 1, ar_dly = 1, r_dly = 1;
    bit all_ones, rand_dly, fixed_resp, chk_en;
    int dut_wr_dones, dut_rd_dones, mdl_wr_dones, mdl_rd_dones;

    // Delay = number of cycles a valid is visible, handshake cycle included.
    function automatic void pick_wr_delays();
        aw_dly = 1 + int'($urandom_range(0, 10));
        w_dly  = 1 + int'($urandom_range(0, 10));
        b_dly  = 1 + int'($urandom_range(0, 10));
    endfunction

    function automatic void pick_rd_delays();
        ar_dly = 1 + int'($urandom_range(0, 10));
        r_dly  = 1 + int'($urandom_range(0, 10));
    endfunction

    // Advances the model by one clock edge using the inputs being applied.
    task automatic model_update();
        if (rst) begin
            m_wr_busy = 0; m_aw_pend = 0; m_w_pend = 0; m_wr_done = 0;
            m_awaddr = '0; m_wdata = '0; m_wr_resp = '0;
            m_rd_busy = 0; m_ar_pend = 0; m_rd_done = 0;
            m_araddr = '0; m_rd_data = '0; m_rd_resp = '0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        end else begin
            m_wr_done = 0;
            if (!m_wr_busy) begin
                if (wr_req) begin
                    m_wr_busy = 1; m_aw_pend = 1; m_w_pend = 1;
                    m_awaddr = wr_addr & ALIGN;
                    m_wdata  = wr_data;
                    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                    if (rand_dly) pick_wr_delays();
                end
            end else if (m_aw_pend || m_w_pend) begin
                if (m_aw_pend) begin
                    if (axi.awready) m_aw_pend = 0; else aw_cnt++;
                end
                if (m_w_pend) begin
                    if (axi.wready) m_w_pend = 0; else w_cnt++;
                end
            end else begin
                if (axi.bvalid) begin
                    m_wr_busy = 0; m_wr_done = 1; m_wr_resp = axi.bresp;
                    mdl_wr_dones++;
                end else b_cnt++;
            end

            m_rd_done = 0;
            if (!m_rd_busy) begin
                if (rd_req) begin
                    m_rd_busy = 1; m_ar_pend = 1;
                    m_araddr = rd_addr & ALIGN;
                    ar_cnt = 0; r_cnt = 0;
                    if (rand_dly) pick_rd_delays();
                end
            end else if (m_ar_pend) begin
                if (axi.arready) m_ar_pend = 0; else ar_cnt++;
            end else begin
                if (axi.rvalid) begin
                    m_rd_busy = 0; m_rd_done = 1;
                    m_rd_data = axi.rdata; m_rd_resp = axi.rresp;
                    mdl_rd_dones++;
                end else r_cnt++;
            end
        end
    endtask

    function automatic bit exp_bready();
        return m_wr_busy && !m_aw_pend && !m_w_pend;
    endfunction

    function automatic bit exp_rready();
        return m_rd_busy && !m_ar_pend;
    endfunction

    // AXI slave behaviour, derived from the model's view of what is pending.
    task automatic drive_slave();
        if (all_ones) begin
            axi.awready = 1; axi.wready = 1; axi.bvalid = 1;
            axi.arready = 1; axi.rvalid = 1;
        end else begin
            axi.awready = m_aw_pend ? (aw_cnt >= aw_dly - 1) : 1'($urandom_range(0, 1));
            axi.wready  = m_w_pend  ? (w_cnt  >= w_dly  - 1) : 1'($urandom_range(0, 1));
            axi.arready = m_ar_pend ? (ar_cnt >= ar_dly - 1) : 1'($urandom_range(0, 1));
            axi.bvalid  = exp_bready() && (b_cnt >= b_dly - 1);
            axi.rvalid  = exp_rready() && (r_cnt >= r_dly - 1);
        end
        if (!fixed_resp) begin
            axi.bresp = 2'($urandom_range(0, 3));
            axi.rresp = 2'($urandom_range(0, 3));
            axi.rdata = $urandom;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        drive_slave();
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("wr_ready", wr_ready, !m_wr_busy);
            check("awvalid", axi.awvalid, m_aw_pend);
            check("wvalid", axi.wvalid, m_w_pend);
            check("bready", axi.bready, exp_bready());
            check("wstrb", axi.wstrb, 4'hF);
            if (m_aw_pend) check("awaddr", axi.awaddr, m_awaddr);
            if (m_w_pend)  check("wdata", axi.wdata, m_wdata);
            check("wr_done", wr_done, m_wr_done);
            if (m_wr_done) check("wr_resp", wr_resp, m_wr_resp);
            check("rd_ready", rd_ready, !m_rd_busy);
            check("arvalid", axi.arvalid, m_ar_pend);
            check("rready", axi.rready, exp_rready());
            if (m_ar_pend) check("araddr", axi.araddr, m_araddr);
            check("rd_done", rd_done, m_rd_done);
            check("rd_data", rd_data, m_rd_data);
            check("rd_resp", rd_resp, m_rd_resp);
            if (wr_done) dut_wr_dones++;
            if (rd_done) dut_rd_dones++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int aw_hi, w_hi, first_bready, n_done, n_rdone;
        bit seen_w, seen_r;

        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rresp = 0; axi.rdata = '0;

        // Reset
        rst = 1;
        step();
        step();
        chk_en = 1;
        check("rst_wr_ready", wr_ready, 1);
        check("rst_rd_ready", rd_ready, 1);
        check("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid}, 3'b000);
        check("rst_readies", {axi.bready, axi.rready}, 2'b00);
        check("rst_dones", {wr_done, rd_done}, 2'b00);
        check("rst_awaddr", axi.awaddr, 0);
        check("rst_wdata", axi.wdata, 0);
        check("rst_araddr", axi.araddr, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_resps", {wr_resp, rd_resp}, 4'h0);
        rst = 0;
        step();

        // Write 0x10 / 0xDEADBEEF, everything ready: done at N+3
        all_ones = 1; fixed_resp = 1; axi.bresp = 2'b00;
        drive_slave();
        wr_req = 1; wr_addr = 32'h10; wr_data = 32'hDEADBEEF;
        step();
        wr_req = 0;
        check("t1_awvalid", axi.awvalid, 1);
        check("t1_awaddr", axi.awaddr, 32'h10);
        check("t1_wdata", axi.wdata, 32'hDEADBEEF);
        check("t1_wr_ready_low", wr_ready, 0);
        step();
        check("t1_awvalid_drop", axi.awvalid, 0);
        check("t1_bready", axi.bready, 1);
        step();
        check("t1_wr_done_n3", wr_done, 1);
        check("t1_wr_resp", wr_resp, 0);
        check("t1_wr_ready_with_done", wr_ready, 1);
        step();
        check("t1_wr_done_pulse", wr_done, 0);

        // Read 0x23 with SLVERR: aligned address, done at N+3
        axi.rdata = 32'h12345678; axi.rresp = 2'b10;
        rd_req = 1; rd_addr = 32'h23;
        step();
        rd_req = 0;
        check("t2_araddr", axi.araddr, 32'h20);
        check("t2_arvalid", axi.arvalid, 1);
        step();
        check("t2_rready", axi.rready, 1);
        step();
        check("t2_rd_done_n3", rd_done, 1);
        check("t2_rd_data", rd_data, 32'h12345678);
        check("t2_rd_resp", rd_resp, 2);
        step();
        check("t2_rd_done_pulse", rd_done, 0);
        check("t2_rd_data_held", rd_data, 32'h12345678);

        // awready after 4 cycles, wready after 1
        all_ones = 0; fixed_resp = 0; rand_dly = 0;
        aw_dly = 4; w_dly = 1; b_dly = 2;
        drive_slave();
        wr_req = 1; wr_addr = 32'h1234_5677; wr_data = 32'hCAFE_0001;
        step();
        wr_req = 0;
        check("t3_awaddr_aligned", axi.awaddr, 32'h1234_5674);
        aw_hi = 0; w_hi = 0; first_bready = 0; n_done = 0;
        for (int i = 1; i <= 12; i++) begin
            if (axi.awvalid) aw_hi++;
            if (axi.wvalid) w_hi++;
            if (axi.bready && first_bready == 0) first_bready = i;
            if (wr_done) n_done++;
            step();
        end
        check("t3_awvalid_cycles", aw_hi, 4);
        check("t3_wvalid_cycles", w_hi, 1);
        check("t3_first_bready", first_bready, 5);
        check("t3_done_count", n_done, 1);

        // Simultaneous write 0x40 and read 0x80 with random delays
        rand_dly = 1;
        wr_req = 1; wr_addr = 32'h40; wr_data = $urandom;
        rd_req = 1; rd_addr = 32'h80;
        step();
        wr_req = 0; rd_req = 0;
        seen_w = 0; seen_r = 0;
        for (int i = 0; i < 80 && !(seen_w && seen_r); i++) begin
            if (wr_done) seen_w = 1;
            if (rd_done) seen_r = 1;
            step();
        end
        check("t4_wr_completed", seen_w, 1);
        check("t4_rd_completed", seen_r, 1);

        // Random traffic, requests also offered while busy
        for (int i = 0; i < 600; i++) begin
            wr_req  = ($urandom_range(0, 2) == 0);
            wr_addr = $urandom;
            wr_data = $urandom;
            rd_req  = ($urandom_range(0, 2) == 0);
            rd_addr = $urandom;
            step();
        end
        wr_req = 0; rd_req = 0;
        for (int i = 0; i < 100 && (m_wr_busy || m_rd_busy); i++) step();
        step();
        check("t5_drained_wr_ready", wr_ready, 1);
        check("t5_drained_rd_ready", rd_ready, 1);
        check("t5_wr_done_total", dut_wr_dones, mdl_wr_dones);
        check("t5_rd_done_total", dut_rd_dones, mdl_rd_dones);

        // Second wr_req while waiting 5 cycles for bvalid is ignored
        rand_dly = 0; aw_dly = 1; w_dly = 1; b_dly = 6;
        drive_slave();
        wr_req = 1; wr_addr = 32'h100; wr_data = 32'h0000_0100;
        step();
        aw_hi = 0; n_done = 0;
        for (int i = 1; i <= 16; i++) begin
            if (axi.awvalid) aw_hi++;
            if (wr_done) n_done++;
            if (i >= 6) wr_req = 0;
            else begin wr_addr = 32'h200; wr_data = 32'h0000_0200; end
            step();
        end
        check("t6_single_done", n_done, 1);
        check("t6_single_aw", aw_hi, 1);

        // Reset while awvalid and arvalid are up
        aw_dly = 20; w_dly = 1; b_dly = 1; ar_dly = 20; r_dly = 1;
        drive_slave();
        wr_req = 1; wr_addr = 32'h300; wr_data = 32'h0000_0300;
        rd_req = 1; rd_addr = 32'h400;
        step();
        wr_req = 0; rd_req = 0;
        step();
        check("t7_awvalid_before", axi.awvalid, 1);
        check("t7_arvalid_before", axi.arvalid, 1);
        rst = 1;
        step();
        rst = 0;
        check("t7_awvalid_dropped", axi.awvalid, 0);
        check("t7_arvalid_dropped", axi.arvalid, 0);
        check("t7_readies_back", {wr_ready, rd_ready}, 2'b11);
        n_done = 0; n_rdone = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (wr_done) n_done++;
            if (rd_done) n_rdone++;
        end
        check("t7_no_wr_done", n_done, 0);
        check("t7_no_rd_done", n_rdone, 0);

        all_ones = 1; fixed_resp = 1; axi.bresp = 2'b00;
        drive_slave();
        wr_req = 1; wr_addr = 32'h500; wr_data = 32'h5555_AAAA;
        step();
        wr_req = 0;
        check("t7_post_awaddr", axi.awaddr, 32'h500);
        step();
        step();
        check("t7_post_wr_done", wr_done, 1);
        check("t7_post_wr_resp", wr_resp, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_axil_master_fsm.md
VGA_AXIL_MASTER_FSM -- requirements
Module: vga_axil_master_fsm

Interface
REQ-001 ADDR_WIDTH, 32, AXI-Lite byte address width.
REQ-002 DATA_WIDTH, 32, AXI-Lite data width; SHALL be 32 or 64.
REQ-003 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 wr_req  in  1  native write request; it is accepted only while wr_ready=1.
REQ-006 wr_addr  in  ADDR_WIDTH  write byte address, sampled on acceptance.
REQ-007 wr_data  in  DATA_WIDTH  write data, sampled on acceptance.
REQ-008 wr_ready  out  1  write FSM idle, so a request can be accepted.
REQ-009 wr_done  out  1  one-cycle pulse marking write completion.
REQ-010 wr_resp  out  2  BRESP captured at completion, valid while wr_done=1.
REQ-011 rd_req  in  1  native read request; it is accepted only while rd_ready=1.
REQ-012 rd_addr  in  ADDR_WIDTH  read byte address, sampled on acceptance.
REQ-013 rd_ready  out  1  read FSM idle.
REQ-014 rd_done  out  1  one-cycle pulse marking read completion.
REQ-015 rd_data  out  DATA_WIDTH  RDATA captured at completion, held until the next completion.
REQ-016 rd_resp  out  2  RRESP captured at completion, held until the next completion.
REQ-017 AW channel: awaddr out ADDR_WIDTH, awvalid out 1, awready in 1.
REQ-018 W channel: wdata out DATA_WIDTH, wstrb out DATA_WIDTH/8, wvalid out 1, wready in 1.
REQ-019 B channel: bresp in 2, bvalid in 1, bready out 1.
REQ-020 AR channel: araddr out ADDR_WIDTH, arvalid out 1, arready in 1.
REQ-021 R channel: rdata in DATA_WIDTH, rresp in 2, rvalid in 1, rready out 1.

Function
REQ-022 The write FSM SHALL have states W_IDLE, W_ADDR_DATA and W_RESP, and the read FSM SHALL have states R_IDLE, R_ADDR and R_DATA; the two FSMs SHALL run independently and concurrently.
REQ-023 W_IDLE: wr_ready=1; on wr_req=1 the block SHALL register wr_addr/wr_data and enter W_ADDR_DATA, raising awvalid=wvalid=1 in the next cycle.
REQ-024 W_ADDR_DATA: awvalid SHALL drop the cycle after awready is sampled high, and wvalid likewise with wready; when both handshakes are complete (same cycle or either order), the FSM SHALL enter W_RESP.
REQ-025 W_RESP: bready=1; on bvalid=1 the block SHALL register bresp into wr_resp, pulse wr_done for the next cycle and return to W_IDLE, where wr_ready=1 in the same cycle as wr_done.
REQ-026 R_IDLE: rd_ready=1; on rd_req=1 the block SHALL register rd_addr, enter R_ADDR and assert arvalid in the next cycle.
REQ-027 R_ADDR: on arready=1 the block SHALL drop arvalid and enter R_DATA.
REQ-028 R_DATA: rready=1; on rvalid=1 the block SHALL register rdata/rresp into rd_data/rd_resp, pulse rd_done for the next cycle and return to R_IDLE.
REQ-029 Any valid SHALL be held high with a stable payload until its handshake completes; the block SHALL NOT deassert a valid early.
REQ-030 awaddr/araddr SHALL be the captured address with the low log2(DATA_WIDTH/8) bits forced to 0.
REQ-031 wstrb SHALL be all ones.
REQ-032 wr_req or rd_req asserted while the matching ready=0 SHALL be ignored, and no state SHALL change.
REQ-033 With all AXI ready/valid inputs held at 1, a request in cycle N SHALL produce its done pulse in cycle N+3.
REQ-034 Any non-OKAY bresp/rresp SHALL be passed through unchanged, with no retry.

Reset
REQ-035 With rst=1 at a clock edge, both FSMs SHALL go to IDLE; all valid, bready, rready and done outputs SHALL be 0; rd_data, rd_resp, wr_resp, awaddr, araddr and wdata SHALL be 0; wr_ready=rd_ready=1 from the first cycle after reset.
REQ-036 A reset mid-transaction SHALL abandon it with no done pulse, and any in-flight valid SHALL drop at that edge.

Verification
REQ-037 Write addr 0x10, data 0xDEADBEEF, all readies 1, bvalid=1, bresp=OKAY -> awaddr=0x10 and wdata=0xDEADBEEF for one cycle; wr_done at N+3 with wr_resp=0.
REQ-038 Read addr 0x23, arready=1, rvalid=1, rdata=0x12345678, rresp=SLVERR -> araddr=0x20; rd_done at N+3 with rd_data=0x12345678, rd_resp=2.
REQ-039 Write with awready delayed 4 cycles and wready delayed 1 -> wvalid drops after 1 cycle; awvalid and its payload hold for 4 cycles; bready rises only after both handshakes complete.
REQ-040 Simultaneous write 0x40 and read 0x80 with random ready delays of 0-10 cycles -> both complete, with channels interleaved and no cross-corruption.
REQ-041 wr_req asserted while W_RESP waits 5 cycles for bvalid -> exactly one wr_done; the second request is ignored.
REQ-042 rst=1 for 1 cycle while awvalid=1 and arvalid=1 -> both drop at the next edge, no done pulse follows, and a following write completes normally.
